// File: rtl/vpu_tile_accum.sv
// vpu_tile_accum
//
// Consumer side of the tiled vector unit. Takes partial-product tiles tagged
// with their (i, j, k) tile base indices and sums them over k into a
// ROW_A x ROW_A accumulator. After the last k step it drains the finished C
// tile to result memory one row per handshake. Once the final tile
// (ROW_M-ROW_A, ROW_M-ROW_A) has been fully written it parks in DONE.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high; clears all state immediately
//   in_valid  in   partial tile beat present
//   in_ready  out  beat can be accepted (ACCUM state)
//   in_i/j/k  in   tile row / column / reduction-step base indices
//   in_tile   in   partial tile, element (r,c) at [(r*ROW_A+c)*ACC_W +: ACC_W]
//   wr_valid  out  result row present (DRAIN state)
//   wr_ready  in   result memory accepts the row
//   wr_row    out  absolute C row = tile_i + r
//   wr_col    out  absolute C base column = tile_j
//   wr_data   out  accumulator row r, element c at [c*ACC_W +: ACC_W]
//   err       out  sticky; an out-of-order beat was received
//   done      out  sticky; the whole matrix has been written
//
// Tile geometry normally comes from config_sys.vh; the defaults below only
// apply when that header has not already defined the macros.

`ifndef ROW_M
`define ROW_M 8
`endif
`ifndef ROW_A
`define ROW_A 4
`endif

module vpu_tile_accum #(
    parameter int ACC_W = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [$clog2(`ROW_M)-1:0]            in_i,
    input  logic [$clog2(`ROW_M)-1:0]            in_j,
    input  logic [$clog2(`ROW_M)-1:0]            in_k,
    input  logic [`ROW_A*`ROW_A*ACC_W-1:0]       in_tile,
    output logic                                 wr_valid,
    input  logic                                 wr_ready,
    output logic [$clog2(`ROW_M)-1:0]            wr_row,
    output logic [$clog2(`ROW_M)-1:0]            wr_col,
    output logic [`ROW_A*ACC_W-1:0]              wr_data,
    output logic                                 err,
    output logic                                 done
);

    localparam int IW = $clog2(`ROW_M);
    localparam int N  = `ROW_A;
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    // Last reduction step base and last tile base share the same value.
    localparam logic [IW-1:0] LAST_BASE = IW'(`ROW_M - `ROW_A);
    localparam logic [IW-1:0] K_STEP    = IW'(`ROW_A);
    localparam logic [RW-1:0] R_LAST    = RW'(N - 1);

    typedef enum logic [1:0] {
        S_ACCUM,
        S_DRAIN,
        S_DONE
    } state_t;

    // Packed [row][col][bit] layout matches the flat port ordering exactly,
    // so acc[r] is already a wr_data-shaped row.
    typedef logic [N-1:0][N-1:0][ACC_W-1:0] tile_t;

    state_t         state;
    tile_t          acc;
    tile_t          beat;
    tile_t          sum;
    logic [RW-1:0]  r;
    logic [IW-1:0]  tile_i;
    logic [IW-1:0]  tile_j;
    logic [IW-1:0]  exp_k;

    logic           accept;
    logic           order_ok;
    logic           wr_fire;

    assign beat = in_tile;

    // Element-wise wrapping add; no saturation.
    for (genvar gr = 0; gr < N; gr++) begin : g_row
        for (genvar gc = 0; gc < N; gc++) begin : g_col
            assign sum[gr][gc] = acc[gr][gc] + beat[gr][gc];
        end
    end

    // Handshake flags decode registered state only, never in_valid/wr_ready.
    assign in_ready = (state == S_ACCUM);
    assign wr_valid = (state == S_DRAIN);
    assign done     = (state == S_DONE);

    assign accept   = in_valid && in_ready;
    assign wr_fire  = wr_valid && wr_ready;

    // A fresh tile must start at k=0; continuation beats must hit the
    // expected k and stay on the latched tile.
    assign order_ok = (in_k == exp_k) &&
                      ((exp_k == '0) || ((in_i == tile_i) && (in_j == tile_j)));

    // Result fields come straight from registers, so they hold while stalled.
    assign wr_row  = tile_i + IW'(r);
    assign wr_col  = tile_j;
    assign wr_data = acc[r];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the accumulator is architecturally visible on wr_data, so
            // it is cleared by reset like any other flop, not left undefined.
            state  <= S_ACCUM;
            acc    <= '0;
            r      <= '0;
            tile_i <= '0;
            tile_j <= '0;
            exp_k  <= '0;
            err    <= 1'b0;
        end else begin
            // NOTE: every state update here uses <= so all flops sample the
            // pre-edge values; a blocking = would leak same-cycle updates.
            case (state)
                S_ACCUM: begin
                    if (accept) begin
                        if (!order_ok) begin
                            err <= 1'b1;
                        end else begin
                            if (in_k == '0) begin
                                acc    <= beat;
                                tile_i <= in_i;
                                tile_j <= in_j;
                            end else begin
                                acc <= sum;
                            end
                            exp_k <= in_k + K_STEP;
                            if (in_k == LAST_BASE) begin
                                state <= S_DRAIN;
                                r     <= '0;
                            end
                        end
                    end
                end

                S_DRAIN: begin
                    if (wr_fire) begin
                        r <= r + 1'b1;
                        if (r == R_LAST) begin
                            exp_k <= '0;
                            if ((tile_i == LAST_BASE) && (tile_j == LAST_BASE))
                                state <= S_DONE;
                            else
                                state <= S_ACCUM;
                        end
                    end
                end

                S_DONE: begin
                    // Terminal until reset; input beats are ignored.
                end

                default: state <= S_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_vpu_tile_accum.sv
`timescale 1ns/1ps

`ifndef ROW_M
`define ROW_M 8
`endif
`ifndef ROW_A
`define ROW_A 4
`endif

module tb_vpu_tile_accum;

    localparam int ACC_W = 32;
    localparam int N     = 4;
    localparam int IW    = 3;
    localparam int DW    = N * ACC_W;
    localparam int TW    = N * N * ACC_W;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [IW-1:0]   in_i;
    logic [IW-1:0]   in_j;
    logic [IW-1:0]   in_k;
    logic [TW-1:0]   in_tile;
    logic            wr_valid;
    logic            wr_ready;
    logic [IW-1:0]   wr_row;
    logic [IW-1:0]   wr_col;
    logic [DW-1:0]   wr_data;
    logic            err;
    logic            done;

    vpu_tile_accum #(.ACC_W(ACC_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_i     (in_i),
        .in_j     (in_j),
        .in_k     (in_k),
        .in_tile  (in_tile),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_row   (wr_row),
        .wr_col   (wr_col),
        .wr_data  (wr_data),
        .err      (err),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per clock cycle: inputs to drive, outputs expected before
    // the next rising edge.
    typedef struct {
        string          name;
        logic           v;
        logic [IW-1:0]  i;
        logic [IW-1:0]  j;
        logic [IW-1:0]  k;
        logic [31:0]    val;
        logic           ramp;
        logic           rdy;
        logic           e_inr;
        logic           e_wv;
        logic [IW-1:0]  e_row;
        logic [IW-1:0]  e_col;
        logic [DW-1:0]  e_data;
        logic           e_err;
        logic           e_done;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;
    logic exp_err  = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Tile with every element = val, or val + element index when ramp is set.
    function automatic logic [TW-1:0] make_tile(input logic [31:0] val, input logic ramp);
        logic [TW-1:0] t;
        t = '0;
        for (int e = 0; e < N * N; e++)
            t[e*ACC_W +: ACC_W] = ramp ? val + 32'(e) : val;
        return t;
    endfunction

    // Expected drained row when two beats were summed; ramped beats add 2*e.
    function automatic logic [DW-1:0] row_data(input logic [31:0] elem, input logic ramp, input int r);
        logic [DW-1:0] d;
        d = '0;
        for (int c = 0; c < N; c++)
            d[c*ACC_W +: ACC_W] = ramp ? elem + 32'(2 * (r * N + c)) : elem;
        return d;
    endfunction

    task automatic push(input string name, input logic v, input logic [IW-1:0] i, input logic [IW-1:0] j,
                        input logic [IW-1:0] k, input logic [31:0] val, input logic ramp, input logic rdy,
                        input logic e_inr, input logic e_wv, input logic [IW-1:0] e_row,
                        input logic [IW-1:0] e_col, input logic [DW-1:0] e_data, input logic e_done);
        vec_t x;
        x.name = name; x.v = v; x.i = i; x.j = j; x.k = k; x.val = val; x.ramp = ramp; x.rdy = rdy;
        x.e_inr = e_inr; x.e_wv = e_wv; x.e_row = e_row; x.e_col = e_col; x.e_data = e_data;
        x.e_err = exp_err; x.e_done = e_done;
        tbl.push_back(x);
    endtask

    // A beat offered in ACCUM; a bad beat makes err visible from the next row on.
    task automatic beat(input string name, input logic [IW-1:0] i, input logic [IW-1:0] j,
                        input logic [IW-1:0] k, input logic [31:0] val, input logic ramp, input logic bad);
        push(name, 1'b1, i, j, k, val, ramp, 1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b0);
        if (bad) exp_err = 1'b1;
    endtask

    // Drain rows 0..nrows-1 of tile (ti,tj); row stall_row first sees stall_n
    // cycles of wr_ready=0.
    task automatic drain(input string name, input int ti, input int tj, input logic [31:0] elem,
                         input logic ramp, input int stall_row, input int stall_n, input int nrows);
        for (int r = 0; r < nrows; r++) begin
            if (r == stall_row)
                for (int s = 0; s < stall_n; s++)
                    push($sformatf("%s.stall%0d", name, s), 1'b0, '0, '0, '0, '0, 1'b0, 1'b0,
                         1'b0, 1'b1, IW'(ti + r), IW'(tj), row_data(elem, ramp, r), 1'b0);
            push($sformatf("%s.row%0d", name, r), 1'b0, '0, '0, '0, '0, 1'b0, 1'b1,
                 1'b0, 1'b1, IW'(ti + r), IW'(tj), row_data(elem, ramp, r), 1'b0);
        end
    endtask

    // Four tiles, two beats each with value k+1 -> every element 1+5=6.
    task automatic full_matrix(input string tag);
        for (int t = 0; t < 4; t++) begin
            int ti, tj;
            ti = (t / 2) * 4;
            tj = (t % 2) * 4;
            beat($sformatf("%s.t%0d.b0", tag, t), IW'(ti), IW'(tj), 3'd0, 32'd1, 1'b0, 1'b0);
            beat($sformatf("%s.t%0d.b1", tag, t), IW'(ti), IW'(tj), 3'd4, 32'd5, 1'b0, 1'b0);
            drain($sformatf("%s.t%0d", tag, t), ti, tj, 32'd6, 1'b0, -1, 0, 4);
        end
        for (int x = 0; x < 3; x++)
            push($sformatf("%s.extra%0d", tag, x), 1'b1, '0, '0, '0, 32'd3, 1'b0, 1'b1,
                 1'b0, 1'b0, '0, '0, '0, 1'b1);
    endtask

    task automatic apply();
        foreach (tbl[n]) begin
            @(negedge clk);
            in_valid = tbl[n].v;
            in_i     = tbl[n].i;
            in_j     = tbl[n].j;
            in_k     = tbl[n].k;
            in_tile  = make_tile(tbl[n].val, tbl[n].ramp);
            wr_ready = tbl[n].rdy;
            check({tbl[n].name, ".in_ready"}, DW'(in_ready), DW'(tbl[n].e_inr));
            check({tbl[n].name, ".wr_valid"}, DW'(wr_valid), DW'(tbl[n].e_wv));
            check({tbl[n].name, ".err"},      DW'(err),      DW'(tbl[n].e_err));
            check({tbl[n].name, ".done"},     DW'(done),     DW'(tbl[n].e_done));
            if (tbl[n].e_wv) begin
                check({tbl[n].name, ".wr_row"},  DW'(wr_row), DW'(tbl[n].e_row));
                check({tbl[n].name, ".wr_col"},  DW'(wr_col), DW'(tbl[n].e_col));
                check({tbl[n].name, ".wr_data"}, wr_data,     tbl[n].e_data);
            end
        end
        tbl.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".in_ready"}, DW'(in_ready), DW'(1'b1));
        check({tag, ".wr_valid"}, DW'(wr_valid), DW'(1'b0));
        check({tag, ".wr_row"},   DW'(wr_row),   '0);
        check({tag, ".wr_col"},   DW'(wr_col),   '0);
        check({tag, ".wr_data"},  wr_data,       '0);
        check({tag, ".err"},      DW'(err),      DW'(1'b0));
        check({tag, ".done"},     DW'(done),     DW'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_i     = '0;
        in_j     = '0;
        in_k     = '0;
        in_tile  = '0;
        wr_ready = 1'b1;

        #12;
        check_reset_values("por");
        @(negedge clk);
        reset = 1'b0;

        // Single tile: 1 + 2 = 3 everywhere.
        beat("single.b0", 3'd0, 3'd0, 3'd0, 32'd1, 1'b0, 1'b0);
        beat("single.b1", 3'd0, 3'd0, 3'd4, 32'd2, 1'b0, 1'b0);
        drain("single", 0, 0, 32'd3, 1'b0, -1, 0, 4);

        // Backpressure: five stalled cycles on row 1.
        beat("bp.b0", 3'd0, 3'd0, 3'd0, 32'd5, 1'b0, 1'b0);
        beat("bp.b1", 3'd0, 3'd0, 3'd4, 32'd6, 1'b0, 1'b0);
        drain("bp", 0, 0, 32'd11, 1'b0, 1, 5, 4);

        // Element placement: distinct value per position, 10+e plus 20+e.
        beat("map.b0", 3'd0, 3'd0, 3'd0, 32'd10, 1'b1, 1'b0);
        beat("map.b1", 3'd0, 3'd0, 3'd4, 32'd20, 1'b1, 1'b0);
        drain("map", 0, 0, 32'd30, 1'b1, -1, 0, 4);

        // Modular wrap: 0xFFFFFFFF + 2 = 1.
        beat("wrap.b0", 3'd0, 3'd0, 3'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        beat("wrap.b1", 3'd0, 3'd0, 3'd4, 32'h0000_0002, 1'b0, 1'b0);
        drain("wrap", 0, 0, 32'h0000_0001, 1'b0, -1, 0, 4);

        // Order errors: wrong k on a fresh tile, then wrong tile on a
        // continuation beat; both are dropped and err sticks.
        beat("ord.bad_k",  3'd0, 3'd0, 3'd4, 32'd7, 1'b0, 1'b1);
        beat("ord.b0",     3'd0, 3'd0, 3'd0, 32'd1, 1'b0, 1'b0);
        beat("ord.bad_ij", 3'd4, 3'd0, 3'd4, 32'd9, 1'b0, 1'b1);
        beat("ord.b1",     3'd0, 3'd0, 3'd4, 32'd1, 1'b0, 1'b0);
        drain("ord", 0, 0, 32'd2, 1'b0, -1, 0, 4);

        full_matrix("full1");
        apply();

        // Reset from DONE, then start a tile and reset mid-drain on row 2.
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check_reset_values("rst_done");
        @(negedge clk);
        reset   = 1'b0;
        exp_err = 1'b0;
        beat("ar.b0", 3'd0, 3'd0, 3'd0, 32'd1, 1'b0, 1'b0);
        beat("ar.b1", 3'd0, 3'd0, 3'd4, 32'd1, 1'b0, 1'b0);
        drain("ar", 0, 0, 32'd2, 1'b0, -1, 0, 2);
        apply();

        @(negedge clk);
        in_valid = 1'b0;
        check("ar.row2.wr_valid", DW'(wr_valid), DW'(1'b1));
        check("ar.row2.wr_row",   DW'(wr_row),   DW'(3'd2));
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("ar.async");
        @(negedge clk);
        reset = 1'b0;

        full_matrix("full2");
        apply();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
